// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - NCO frequency-step sweep controller (single / repeat / bounce)
module nco_sweep_ctrl #(
    parameter int FSTEP_W = 14,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [1:0]         mode_i,
    input  logic [FSTEP_W-1:0] start_step_i,
    input  logic [FSTEP_W-1:0] stop_step_i,
    input  logic [FSTEP_W-1:0] inc_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [FSTEP_W-1:0] freq_step_o,
    output logic               step_valid_o,
    output logic               nco_en_o,
    output logic               busy_o,
    output logic               done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DWELL = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    state_t state_q, state_d;

    // Configuration captured when a sweep is accepted; the live inputs are
    // ignored for the rest of the sweep.
    logic [FSTEP_W-1:0] start_q;
    logic [FSTEP_W-1:0] stop_q;
    logic [FSTEP_W-1:0] inc_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [1:0]         mode_q;
    logic               up_q;     // stop >= start: stepping toward stop is upward
    logic               fwd_q;    // bounce heading: 1 toward stop, 0 toward start

    logic [FSTEP_W-1:0] freq_q;
    logic               step_valid_q;
    logic [DWELL_W-1:0] cnt_q;    // cycles the current value has been shown, minus one

    logic               accept;
    logic               active;
    logic               expired;
    logic               at_stop;
    logic               at_start;
    logic               load_start;
    logic               load_step;
    logic [FSTEP_W-1:0] next_val;
    logic               next_fwd;
    logic [FSTEP_W-1:0] toward_stop;
    logic [FSTEP_W-1:0] toward_start;

    // One step from cur toward tgt, clamped at tgt. The extra bit catches
    // both carry out of the top and borrow below zero, so it never wraps.
    function automatic logic [FSTEP_W-1:0] step_toward(
        input logic [FSTEP_W-1:0] cur,
        input logic [FSTEP_W-1:0] tgt,
        input logic [FSTEP_W-1:0] inc,
        input logic               up
    );
        logic [FSTEP_W:0] sum;
        logic [FSTEP_W:0] diff;
        logic [FSTEP_W-1:0] res;
        sum  = {1'b0, cur} + {1'b0, inc};
        diff = {1'b0, cur} - {1'b0, inc};
        if (up) begin
            if (sum >= {1'b0, tgt}) res = tgt;
            else                    res = sum[FSTEP_W-1:0];
        end else begin
            if (diff[FSTEP_W] || (diff[FSTEP_W-1:0] <= tgt)) res = tgt;
            else                                             res = diff[FSTEP_W-1:0];
        end
        return res;
    endfunction

    assign accept       = start_i && !stop_i;
    assign active       = (state_q == DWELL) || (state_q == STEP);
    assign expired      = (cnt_q == dwell_q);
    assign at_stop      = (freq_q == stop_q);
    assign at_start     = (freq_q == start_q);
    assign toward_stop  = step_toward(freq_q, stop_q, inc_q, up_q);
    assign toward_start = step_toward(freq_q, start_q, inc_q, !up_q);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and the choice of the next frequency value at dwell expiry.
    always_comb begin
        state_d    = state_q;
        load_start = 1'b0;
        load_step  = 1'b0;
        next_val   = freq_q;
        next_fwd   = fwd_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = DWELL;
                    load_start = 1'b1;
                end
            end
            DWELL, STEP: begin
                if (stop_i) begin
                    state_d = IDLE;
                end else if (expired) begin
                    case (mode_q)
                        MODE_REPEAT: begin
                            state_d   = STEP;
                            load_step = 1'b1;
                            next_val  = at_stop ? start_q : toward_stop;
                        end
                        MODE_BOUNCE: begin
                            state_d   = STEP;
                            load_step = 1'b1;
                            if (fwd_q) begin
                                if (at_stop) begin
                                    next_fwd = 1'b0;
                                    next_val = toward_start;
                                end else begin
                                    next_val = toward_stop;
                                end
                            end else begin
                                if (at_start) begin
                                    next_fwd = 1'b1;
                                    next_val = toward_stop;
                                end else begin
                                    next_val = toward_start;
                                end
                            end
                        end
                        default: begin
                            if (at_stop) begin
                                state_d = DONE;
                            end else begin
                                state_d   = STEP;
                                load_step = 1'b1;
                                next_val  = toward_stop;
                            end
                        end
                    endcase
                end else begin
                    state_d = DWELL;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Config latch, frequency register and dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q      <= '0;
            stop_q       <= '0;
            inc_q        <= '0;
            dwell_q      <= '0;
            mode_q       <= '0;
            up_q         <= 1'b0;
            fwd_q        <= 1'b0;
            freq_q       <= '0;
            step_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            step_valid_q <= load_start || load_step;
            if (load_start) begin
                start_q <= start_step_i;
                stop_q  <= stop_step_i;
                inc_q   <= (inc_i == '0) ? {{(FSTEP_W-1){1'b0}}, 1'b1} : inc_i;
                dwell_q <= dwell_i;
                mode_q  <= mode_i;
                up_q    <= (stop_step_i >= start_step_i);
                fwd_q   <= 1'b1;
                freq_q  <= start_step_i;
                cnt_q   <= '0;
            end else if (load_step) begin
                freq_q <= next_val;
                fwd_q  <= next_fwd;
                cnt_q  <= '0;
            end else if (active && !expired) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign freq_step_o  = freq_q;
    assign step_valid_o = step_valid_q;
    assign busy_o       = active;
    assign nco_en_o     = active;
    assign done_o       = (state_q == DONE);

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - directed self-checking bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

    localparam int FSTEP_W = 14;
    localparam int DWELL_W = 16;

    logic               clk;
    logic               rst;
    logic               start_i;
    logic               stop_i;
    logic [1:0]         mode_i;
    logic [FSTEP_W-1:0] start_step_i;
    logic [FSTEP_W-1:0] stop_step_i;
    logic [FSTEP_W-1:0] inc_i;
    logic [DWELL_W-1:0] dwell_i;
    logic [FSTEP_W-1:0] freq_step_o;
    logic               step_valid_o;
    logic               nco_en_o;
    logic               busy_o;
    logic               done_o;

    int n_checks = 0;
    int n_bad    = 0;

    nco_sweep_ctrl #(.FSTEP_W(FSTEP_W), .DWELL_W(DWELL_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .mode_i       (mode_i),
        .start_step_i (start_step_i),
        .stop_step_i  (stop_step_i),
        .inc_i        (inc_i),
        .dwell_i      (dwell_i),
        .freq_step_o  (freq_step_o),
        .step_valid_o (step_valid_o),
        .nco_en_o     (nco_en_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Check all outputs for the current cycle, then advance to the next sample point.
    task automatic expect_cyc(input string tag, input int f, input logic sv, input logic b, input logic d);
        check({tag, ".freq"}, 32'(freq_step_o), 32'(f));
        check({tag, ".valid"}, 32'(step_valid_o), 32'(sv));
        check({tag, ".busy"}, 32'(busy_o), 32'(b));
        check({tag, ".nco_en"}, 32'(nco_en_o), 32'(b));
        check({tag, ".done"}, 32'(done_o), 32'(d));
        @(negedge clk);
    endtask

    // Called at the cycle-0 sample point; returns at the cycle-1 sample point.
    // Config inputs are scrambled afterwards so later sampling would show up.
    task automatic start_sweep(input logic [1:0] m, input int s, input int e, input int inc, input int dw);
        mode_i       = m;
        start_step_i = FSTEP_W'(s);
        stop_step_i  = FSTEP_W'(e);
        inc_i        = FSTEP_W'(inc);
        dwell_i      = DWELL_W'(dw);
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
        mode_i       = 2'b01;
        start_step_i = FSTEP_W'(1234);
        stop_step_i  = FSTEP_W'(4321);
        inc_i        = FSTEP_W'(77);
        dwell_i      = DWELL_W'(5);
    endtask

    initial begin
        int bounce_pat[4];
        int rep_pat[10];
        bounce_pat = '{5, 6, 7, 6};
        rep_pat    = '{30, 30, 20, 20, 10, 10, 30, 30, 20, 20};

        rst = 1'b1; start_i = 1'b0; stop_i = 1'b0; mode_i = 2'b00;
        start_step_i = '0; stop_step_i = '0; inc_i = '0; dwell_i = '0;
        repeat (2) @(negedge clk);
        expect_cyc("reset", 0, 0, 0, 0);
        rst = 1'b0;
        expect_cyc("idle", 0, 0, 0, 0);

        // single up sweep
        start_sweep(2'b00, 100, 130, 10, 2);
        for (int k = 1; k <= 12; k++)
            expect_cyc("single", 100 + 10 * ((k - 1) / 3), (k % 3) == 1, 1'b1, 1'b0);
        expect_cyc("single_done", 130, 0, 0, 1);
        expect_cyc("single_idle", 130, 0, 0, 0);

        // clamp at stop
        start_sweep(2'b00, 0, 25, 10, 0);
        expect_cyc("clamp1", 0, 1, 1, 0);
        expect_cyc("clamp2", 10, 1, 1, 0);
        expect_cyc("clamp3", 20, 1, 1, 0);
        expect_cyc("clamp4", 25, 1, 1, 0);
        expect_cyc("clamp_done", 25, 0, 0, 1);

        // top saturation, no wrap
        start_sweep(2'b00, 16380, 16383, 5, 0);
        expect_cyc("top1", 16380, 1, 1, 0);
        expect_cyc("top2", 16383, 1, 1, 0);
        expect_cyc("top_done", 16383, 0, 0, 1);

        // mode 11 acts as single, inc 0 acts as 1
        start_sweep(2'b11, 3, 5, 0, 0);
        expect_cyc("inc0_1", 3, 1, 1, 0);
        expect_cyc("inc0_2", 4, 1, 1, 0);
        expect_cyc("inc0_3", 5, 1, 1, 0);
        expect_cyc("inc0_done", 5, 0, 0, 1);

        // start == stop, single: one dwell then done
        start_sweep(2'b00, 9, 9, 3, 1);
        expect_cyc("eq1", 9, 1, 1, 0);
        expect_cyc("eq2", 9, 0, 1, 0);
        expect_cyc("eq_done", 9, 0, 0, 1);

        // start == stop, repeat: pulse every expiry
        start_sweep(2'b01, 4, 4, 3, 0);
        for (int k = 1; k <= 3; k++) expect_cyc("eq_rep", 4, 1, 1, 0);
        stop_i = 1'b1;
        expect_cyc("eq_rep_last", 4, 1, 1, 0);
        stop_i = 1'b0;
        expect_cyc("eq_rep_stop", 4, 0, 0, 0);

        // bounce, with an ignored start while busy
        start_sweep(2'b10, 5, 7, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            start_i = (k == 3);
            start_step_i = FSTEP_W'(900);
            expect_cyc("bounce", bounce_pat[(k - 1) % 4], 1, 1, 0);
        end
        start_i = 1'b0;
        stop_i = 1'b1;
        expect_cyc("bounce_last", 7, 1, 1, 0);
        stop_i = 1'b0;
        expect_cyc("bounce_stop", 7, 0, 0, 0);

        // repeat down
        start_sweep(2'b01, 30, 10, 10, 1);
        for (int k = 1; k <= 10; k++)
            expect_cyc("repeat", rep_pat[k - 1], (k % 2) == 1, 1'b1, 1'b0);
        stop_i = 1'b1;
        expect_cyc("repeat_last", 10, 1, 1, 0);
        stop_i = 1'b0;
        expect_cyc("repeat_stop", 10, 0, 0, 0);

        // abort at cycle 5
        start_sweep(2'b00, 100, 130, 10, 2);
        for (int k = 1; k <= 4; k++)
            expect_cyc("abort_pre", 100 + 10 * ((k - 1) / 3), (k % 3) == 1, 1'b1, 1'b0);
        stop_i = 1'b1;
        expect_cyc("abort5", 110, 0, 1, 0);
        stop_i = 1'b0;
        expect_cyc("abort6", 110, 0, 0, 0);
        expect_cyc("abort7", 110, 0, 0, 0);

        // start and stop together in idle
        mode_i = 2'b00; start_step_i = FSTEP_W'(50); stop_step_i = FSTEP_W'(60);
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        expect_cyc("both1", 110, 0, 0, 0);
        expect_cyc("both2", 110, 0, 0, 0);

        // reset mid-sweep
        start_sweep(2'b00, 100, 130, 10, 2);
        expect_cyc("rst_pre1", 100, 1, 1, 0);
        expect_cyc("rst_pre2", 100, 0, 1, 0);
        rst = 1'b1;
        expect_cyc("rst_pre3", 100, 0, 1, 0);
        rst = 1'b0;
        expect_cyc("rst_mid", 0, 0, 0, 0);
        expect_cyc("rst_after", 0, 0, 0, 0);

        // reset beats start
        mode_i = 2'b00; start_step_i = FSTEP_W'(40); stop_step_i = FSTEP_W'(60);
        rst = 1'b1; start_i = 1'b1;
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        expect_cyc("rst_prio", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/nco_sweep_ctrl.md
NCO_SWEEP_CTRL -- requirements
Module: nco_sweep_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- FSTEP_W, 14, width of the NCO frequency step.
- DWELL_W, 16, width of the dwell counter.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single system clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start_i  in  1  one-cycle pulse; begin a sweep.
- stop_i  in  1  one-cycle pulse; abort the sweep.
- mode_i  in  2  00 single, 01 repeat, 10 bounce, 11 treated as single.
- start_step_i  in  FSTEP_W  first frequency step.
- stop_step_i  in  FSTEP_W  final frequency step.
- inc_i  in  FSTEP_W  step increment magnitude.
- dwell_i  in  DWELL_W  each value is held for dwell_i+1 cycles.
- freq_step_o  out  FSTEP_W  frequency step driven to the NCO.
- step_valid_o  out  1  one-cycle pulse when freq_step_o takes a new value.
- nco_en_o  out  1  NCO enable; high while sweeping.
- busy_o  out  1  high while a sweep is active.
- done_o  out  1  one-cycle pulse when a single-mode sweep completes.

Function
REQ-003 The state machine SHALL have the states IDLE, DWELL, STEP and DONE; STEP and DONE last one cycle each.
REQ-004 In IDLE, start_i=1 with stop_i=0 SHALL latch all config inputs; config inputs SHALL NOT be sampled at any other time.
REQ-005 Start acceptance at cycle N SHALL give, from N+1: freq_step_o=start_step, step_valid_o=1 for one cycle, busy_o=1, nco_en_o=1, state DWELL.
REQ-006 Direction SHALL be fixed at start: up if stop_step>=start_step, otherwise down.
REQ-007 An inc_i value of 0 SHALL be treated as 1.
REQ-008 Each value SHALL be held exactly dwell+1 cycles, including the STEP transition cycle, so the next value appears dwell+1 cycles after the previous one.
REQ-009 Next value arithmetic SHALL use FSTEP_W+1 bits: up = min(cur+inc, stop); down = max(cur-inc, stop) with borrow detected; it SHALL never wrap modulo 2^FSTEP_W.
REQ-010 Single mode: when the dwell on the stop value expires, the block SHALL enter DONE.
REQ-011 DONE SHALL assert done_o=1 for one cycle, deassert busy_o and nco_en_o in that same cycle, then return to IDLE; freq_step_o SHALL retain its last value.
REQ-012 Repeat mode: after the dwell on the stop value, the next value SHALL be start_step; the sweep SHALL never complete on its own.
REQ-013 Bounce mode: on reaching stop_step the direction SHALL reverse and the sweep SHALL head toward start_step, reversing again there.
REQ-014 In bounce mode, the turn values (stop_step and start_step) SHALL each be emitted once per turn, not twice.
REQ-015 start_step==stop_step: single mode SHALL complete after one dwell; repeat and bounce SHALL hold the value with a step_valid_o pulse at each dwell expiry.
REQ-016 stop_i while busy, in any state, SHALL force IDLE on the next cycle with busy_o=0 and nco_en_o=0, no done_o pulse, and freq_step_o held.
REQ-017 stop_i and start_i in the same cycle SHALL give stop priority; no sweep starts.
REQ-018 start_i while busy SHALL be ignored.
REQ-019 step_valid_o SHALL pulse only on a freq_step_o load (start, or STEP); it SHALL never pulse in IDLE or DONE.

Reset
REQ-020 rst=1 at a rising edge SHALL set state IDLE and the outputs freq_step_o=0, step_valid_o=0, nco_en_o=0, busy_o=0, done_o=0; the dwell counter and latched config SHALL be cleared.
REQ-021 Reset mid-sweep SHALL abort the sweep with no done_o pulse.
REQ-022 rst SHALL take priority over start_i and stop_i.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Single up sweep (start=100, stop=130, inc=10, dwell=2, start at cycle 0) -> freq_step_o 100 @1-3, 110 @4-6, 120 @7-9, 130 @10-12; done_o=1 @13, busy_o=0 @13.
- Clamp (start=0, stop=25, inc=10, dwell=0, single) -> values 0, 10, 20, 25, then done_o.
- Top saturation (start=16380, stop=16383, inc=5, dwell=0) -> values 16380, 16383; no wrap to 0.
- Bounce (start=5, stop=7, inc=1, dwell=0) -> 5, 6, 7, 6, 5, 6, 7, ... one value per cycle; step_valid_o high every cycle.
- Repeat down (start=30, stop=10, inc=10, dwell=1) -> 30, 20, 10, 30, 20, ... each held 2 cycles.
- Abort and reset -> stop_i at cycle 5 of a sweep gives busy_o=0 and nco_en_o=0 @6, no done_o. start_i+stop_i together in IDLE give no start. rst mid-sweep gives all outputs 0 next cycle.
